hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 48 ++++
 rtl/hazard_ctrl_sat_counter.sv | 22 ++
 rtl/hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_hazard_ctrl.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and register-match helpers for the hazard controller.
// The Fwd select encodings are also the ones used by execute's operand muxes.
package hazard_ctrl_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LDSTALL  = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    reg_idx_t dst;
    logic     wr_en;
  } reg_write_t;

  // x0 is hard-wired to zero, so a write to it never creates a dependency.
  function automatic logic writes_reg(input reg_write_t w, input reg_idx_t src);
    return w.wr_en && (w.dst != '0) && (w.dst == src);
  endfunction

  function automatic logic id_reads(input reg_write_t w,
                                    input reg_idx_t   rs1,
                                    input logic       used1,
                                    input reg_idx_t   rs2,
                                    input logic       used2);
    return (used1 && writes_reg(w, rs1)) || (used2 && writes_reg(w, rs2));
  endfunction

  // The younger producer (memory stage) holds the newer value.
  function automatic fwd_sel_e fwd_select(input reg_write_t mem_w,
                                          input reg_write_t wb_w,
                                          input reg_idx_t   src);
    if (writes_reg(mem_w, src)) return FWD_MEM;
    if (writes_reg(wb_w, src))  return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and redirect performance counts.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: redirect flush, RAW stall and operand forwarding.
// Define HAZARD_FORWARD_EN for load-use stalls plus forwarding; otherwise every RAW stalls.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       i_id_Rs1,
  input  logic [4:0]       i_id_Rs2,
  input  logic             i_id_Rs1Used,
  input  logic             i_id_Rs2Used,
  input  logic [4:0]       i_ex_Rs1,
  input  logic [4:0]       i_ex_Rs2,
  input  logic [4:0]       i_ex_RegDst,
  input  logic             i_ex_RegWrEn,
  input  logic             i_ex_MemToReg,
  input  logic [4:0]       i_mem_RegDst,
  input  logic             i_mem_RegWrEn,
  input  logic             i_mem_Branch,
  input  logic             i_mem_Zero,
  input  logic             i_mem_Jump,
  input  logic [4:0]       i_wb_RegDst,
  input  logic             i_wb_RegWrEn,
  output logic             o_ctr_StallIF,
  output logic             o_ctr_StallID,
  output logic             o_ctr_FlushID,
  output logic             o_ctr_FlushEX,
  output logic             o_ctr_FlushMEM,
  output logic             o_ctr_PcSel,
  output logic [1:0]       o_ctr_Fwd1Sel,
  output logic [1:0]       o_ctr_Fwd2Sel,
  output logic [CNT_W-1:0] o_ctr_StallCnt,
  output logic [CNT_W-1:0] o_ctr_FlushCnt,
  output logic [1:0]       o_ctr_State
);

  reg_write_t ex_w;
  reg_write_t mem_w;
  reg_write_t wb_w;
  state_e     state;
  state_e     state_next;
  fwd_sel_e   fwd1;
  fwd_sel_e   fwd2;
  logic       taken;
  logic       ex_visible;
  logic       id_hit_ex;
  logic       hazard;
  logic       stall;
  logic       flush;

  assign ex_w  = '{dst: i_ex_RegDst,  wr_en: i_ex_RegWrEn};
  assign mem_w = '{dst: i_mem_RegDst, wr_en: i_mem_RegWrEn};
  assign wb_w  = '{dst: i_wb_RegDst,  wr_en: i_wb_RegWrEn};

  assign taken = (i_mem_Branch & i_mem_Zero) | i_mem_Jump;

  // During REDIRECT execute holds the bubble we just flushed in, so its fields are stale.
  assign ex_visible = (state != ST_REDIRECT);
  assign id_hit_ex  = ex_visible &&
                      id_reads(ex_w, i_id_Rs1, i_id_Rs1Used, i_id_Rs2, i_id_Rs2Used);

`ifdef HAZARD_FORWARD_EN
  assign hazard = i_ex_MemToReg && id_hit_ex;
  assign fwd1   = fwd_select(mem_w, wb_w, i_ex_Rs1);
  assign fwd2   = fwd_select(mem_w, wb_w, i_ex_Rs2);
`else
  logic unused_fwd_inputs;

  // Without bypass paths decode must wait until no in-flight stage still owes it a value.
  assign hazard = id_hit_ex ||
                  id_reads(mem_w, i_id_Rs1, i_id_Rs1Used, i_id_Rs2, i_id_Rs2Used) ||
                  id_reads(wb_w,  i_id_Rs1, i_id_Rs1Used, i_id_Rs2, i_id_Rs2Used);
  assign fwd1   = FWD_RF;
  assign fwd2   = FWD_RF;
  assign unused_fwd_inputs = ^{i_ex_MemToReg, i_ex_Rs1, i_ex_Rs2};
`endif

  // A redirect discards decode anyway, so it overrides any stall request.
  assign flush = !reset && taken;
  assign stall = !reset && !taken && hazard;

  always_comb begin
    // NOTE: every output gets a default first so no path through the block can infer a latch.
    state_next     = ST_RUN;
    o_ctr_StallIF  = 1'b0;
    o_ctr_StallID  = 1'b0;
    o_ctr_FlushID  = 1'b0;
    o_ctr_FlushEX  = 1'b0;
    o_ctr_FlushMEM = 1'b0;
    o_ctr_PcSel    = 1'b0;
    o_ctr_Fwd1Sel  = FWD_RF;
    o_ctr_Fwd2Sel  = FWD_RF;

    if (flush) begin
      state_next     = ST_REDIRECT;
      o_ctr_PcSel    = 1'b1;
      o_ctr_FlushID  = 1'b1;
      o_ctr_FlushEX  = 1'b1;
      o_ctr_FlushMEM = 1'b1;
    end else if (stall) begin
      state_next     = ST_LDSTALL;
      o_ctr_StallIF  = 1'b1;
      o_ctr_StallID  = 1'b1;
      o_ctr_FlushEX  = 1'b1;
    end

    if (!reset) begin
      o_ctr_Fwd1Sel = fwd1;
      o_ctr_Fwd2Sel = fwd2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  assign o_ctr_State = state;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall),
    .count (o_ctr_StallCnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush),
    .count (o_ctr_FlushCnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared against a rule-level reference model; follows HAZARD_FORWARD_EN like the RTL.
module tb_hazard_ctrl;

  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef HAZARD_FORWARD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  localparam logic [5:0] CTL_NONE  = 6'b000000;
  localparam logic [5:0] CTL_STALL = 6'b110100;
  localparam logic [5:0] CTL_REDIR = 6'b001111;

  typedef struct packed {
    logic [4:0] id_rs1, id_rs2;
    logic       id_u1, id_u2;
    logic [4:0] ex_rs1, ex_rs2, ex_dst;
    logic       ex_we, ex_ld;
    logic [4:0] mem_dst;
    logic       mem_we, br, zero, jmp;
    logic [4:0] wb_dst;
    logic       wb_we;
  } stim_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] i_id_Rs1, i_id_Rs2, i_ex_Rs1, i_ex_Rs2, i_ex_RegDst, i_mem_RegDst, i_wb_RegDst;
  logic i_id_Rs1Used, i_id_Rs2Used, i_ex_RegWrEn, i_ex_MemToReg, i_mem_RegWrEn;
  logic i_mem_Branch, i_mem_Zero, i_mem_Jump, i_wb_RegWrEn;
  logic o_ctr_StallIF, o_ctr_StallID, o_ctr_FlushID, o_ctr_FlushEX, o_ctr_FlushMEM, o_ctr_PcSel;
  logic [1:0] o_ctr_Fwd1Sel, o_ctr_Fwd2Sel, o_ctr_State;
  logic [CNT_W-1:0] o_ctr_StallCnt, o_ctr_FlushCnt;
  logic [5:0] a_ctl;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: architectural state plus the expectations for the current cycle.
  int m_state = 0;
  int m_stall_cnt = 0;
  int m_flush_cnt = 0;
  logic [5:0] e_ctl;
  logic [1:0] e_f1, e_f2;
  bit e_stall, e_taken;
  int e_next;

  always #5 clk = ~clk;

  assign a_ctl = {o_ctr_StallIF, o_ctr_StallID, o_ctr_FlushID,
                  o_ctr_FlushEX, o_ctr_FlushMEM, o_ctr_PcSel};

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .i_id_Rs1(i_id_Rs1), .i_id_Rs2(i_id_Rs2),
    .i_id_Rs1Used(i_id_Rs1Used), .i_id_Rs2Used(i_id_Rs2Used),
    .i_ex_Rs1(i_ex_Rs1), .i_ex_Rs2(i_ex_Rs2), .i_ex_RegDst(i_ex_RegDst),
    .i_ex_RegWrEn(i_ex_RegWrEn), .i_ex_MemToReg(i_ex_MemToReg),
    .i_mem_RegDst(i_mem_RegDst), .i_mem_RegWrEn(i_mem_RegWrEn),
    .i_mem_Branch(i_mem_Branch), .i_mem_Zero(i_mem_Zero), .i_mem_Jump(i_mem_Jump),
    .i_wb_RegDst(i_wb_RegDst), .i_wb_RegWrEn(i_wb_RegWrEn),
    .o_ctr_StallIF(o_ctr_StallIF), .o_ctr_StallID(o_ctr_StallID),
    .o_ctr_FlushID(o_ctr_FlushID), .o_ctr_FlushEX(o_ctr_FlushEX),
    .o_ctr_FlushMEM(o_ctr_FlushMEM), .o_ctr_PcSel(o_ctr_PcSel),
    .o_ctr_Fwd1Sel(o_ctr_Fwd1Sel), .o_ctr_Fwd2Sel(o_ctr_Fwd2Sel),
    .o_ctr_StallCnt(o_ctr_StallCnt), .o_ctr_FlushCnt(o_ctr_FlushCnt),
    .o_ctr_State(o_ctr_State)
  );

  function automatic bit raw(input logic [4:0] dst, input logic we,
                             input logic [4:0] src, input logic used);
    return used && we && (dst != 5'd0) && (dst == src);
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.id_rs1  = 5'($urandom_range(0, 3));
    s.id_rs2  = 5'($urandom_range(0, 3));
    s.id_u1   = 1'($urandom_range(0, 1));
    s.id_u2   = 1'($urandom_range(0, 1));
    s.ex_rs1  = 5'($urandom_range(0, 3));
    s.ex_rs2  = 5'($urandom_range(0, 3));
    s.ex_dst  = 5'($urandom_range(0, 3));
    s.ex_we   = 1'($urandom_range(0, 1));
    s.ex_ld   = 1'($urandom_range(0, 1));
    s.mem_dst = 5'($urandom_range(0, 3));
    s.mem_we  = 1'($urandom_range(0, 1));
    s.br      = ($urandom_range(0, 3) == 0);
    s.zero    = 1'($urandom_range(0, 1));
    s.jmp     = ($urandom_range(0, 9) == 0);
    s.wb_dst  = 5'($urandom_range(0, 3));
    s.wb_we   = 1'($urandom_range(0, 1));
    return s;
  endfunction

  // Expected controls straight from the hazard rules for the stimulus and model state.
  function automatic void model_eval(input stim_t s);
    bit taken, hit_ex, hit_mem, hit_wb, hazard;
    taken   = (s.br && s.zero) || s.jmp;
    hit_ex  = (m_state != 2) && (raw(s.ex_dst, s.ex_we, s.id_rs1, s.id_u1) ||
                                 raw(s.ex_dst, s.ex_we, s.id_rs2, s.id_u2));
    hit_mem = raw(s.mem_dst, s.mem_we, s.id_rs1, s.id_u1) || raw(s.mem_dst, s.mem_we, s.id_rs2, s.id_u2);
    hit_wb  = raw(s.wb_dst, s.wb_we, s.id_rs1, s.id_u1) || raw(s.wb_dst, s.wb_we, s.id_rs2, s.id_u2);
    hazard  = FWD_ON ? (hit_ex && s.ex_ld) : (hit_ex || hit_mem || hit_wb);
    e_f1 = !FWD_ON ? 2'b00 : raw(s.mem_dst, s.mem_we, s.ex_rs1, 1'b1) ? 2'b01 :
                             raw(s.wb_dst, s.wb_we, s.ex_rs1, 1'b1) ? 2'b10 : 2'b00;
    e_f2 = !FWD_ON ? 2'b00 : raw(s.mem_dst, s.mem_we, s.ex_rs2, 1'b1) ? 2'b01 :
                             raw(s.wb_dst, s.wb_we, s.ex_rs2, 1'b1) ? 2'b10 : 2'b00;
    if (reset) begin
      taken = 1'b0; hazard = 1'b0; e_f1 = 2'b00; e_f2 = 2'b00;
    end
    e_taken = taken;
    e_stall = hazard && !taken;
    e_ctl   = {e_stall, e_stall, e_taken, e_taken || e_stall, e_taken, e_taken};
    e_next  = e_taken ? 2 : (e_stall ? 1 : 0);
  endfunction

  task automatic drive(input stim_t s);
    i_id_Rs1 = s.id_rs1;  i_id_Rs2 = s.id_rs2;  i_id_Rs1Used = s.id_u1; i_id_Rs2Used = s.id_u2;
    i_ex_Rs1 = s.ex_rs1;  i_ex_Rs2 = s.ex_rs2;  i_ex_RegDst = s.ex_dst;
    i_ex_RegWrEn = s.ex_we; i_ex_MemToReg = s.ex_ld;
    i_mem_RegDst = s.mem_dst; i_mem_RegWrEn = s.mem_we;
    i_mem_Branch = s.br; i_mem_Zero = s.zero; i_mem_Jump = s.jmp;
    i_wb_RegDst = s.wb_dst; i_wb_RegWrEn = s.wb_we;
  endtask

  // Drive just after a rising edge, then settle to the falling edge for sampling.
  task automatic apply(input stim_t s);
    drive(s);
    model_eval(s);
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_state = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    end else begin
      m_state = e_next;
      if (e_stall && m_stall_cnt < CNT_MAX) m_stall_cnt++;
      if (e_taken && m_flush_cnt < CNT_MAX) m_flush_cnt++;
    end
    #1;
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    m_state = 0; m_stall_cnt = 0; m_flush_cnt = 0;
  endtask

  task automatic do_reset();
    drive(idle_stim());
    assert_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    stim_t s;
    assert_reset();
    for (int i = 0; i < 4; i++) begin
      s = rand_stim();
      s.br = 1'b1; s.zero = 1'(i % 2);
      s.ex_dst = 5'd2; s.ex_we = 1'b1; s.ex_ld = 1'b1; s.id_rs1 = 5'd2; s.id_u1 = 1'b1;
      s.mem_dst = 5'd1; s.mem_we = 1'b1; s.ex_rs1 = 5'd1; s.ex_rs2 = 5'd1;
      apply(s);
      n_cmp++;
      if ({a_ctl, o_ctr_Fwd1Sel, o_ctr_Fwd2Sel} !== 10'd0) begin
        n_bad++; $display("FAIL reset_ctl: got %b expected all zero", {a_ctl, o_ctr_Fwd1Sel, o_ctr_Fwd2Sel});
      end
      n_cmp++;
      if ({o_ctr_State, o_ctr_StallCnt, o_ctr_FlushCnt} !== '0) begin
        n_bad++; $display("FAIL reset_status: state %0d stall %0d flush %0d expected 0 0 0",
                          o_ctr_State, o_ctr_StallCnt, o_ctr_FlushCnt);
      end
      tick();
    end
    drive(idle_stim());
    reset = 1'b0;
  endtask

  task automatic test_load_use();
    stim_t s;
    do_reset();
    s = idle_stim();
    s.ex_dst = 5'd5; s.ex_we = 1'b1; s.ex_ld = 1'b1; s.id_rs1 = 5'd5; s.id_u1 = 1'b1;
    apply(s);
    n_cmp++;
    if (a_ctl !== CTL_STALL || o_ctr_State !== 2'd0 || o_ctr_StallCnt !== 16'd0) begin
      n_bad++; $display("FAIL load_use_hit: ctl %b state %0d cnt %0d expected %b 0 0",
                        a_ctl, o_ctr_State, o_ctr_StallCnt, CTL_STALL);
    end
    tick();
    apply(idle_stim());
    n_cmp++;
    if (a_ctl !== CTL_NONE || o_ctr_State !== 2'd1 || o_ctr_StallCnt !== 16'd1) begin
      n_bad++; $display("FAIL load_use_bubble: ctl %b state %0d cnt %0d expected %b 1 1",
                        a_ctl, o_ctr_State, o_ctr_StallCnt, CTL_NONE);
    end
    tick();
    apply(idle_stim());
    n_cmp++;
    if (o_ctr_State !== 2'd0) begin
      n_bad++; $display("FAIL load_use_return: state %0d expected 0", o_ctr_State);
    end
    tick();
    // Matching source without its Used flag, and a load to x0, must not stall.
    s.id_u1 = 1'b0;
    apply(s);
    n_cmp++;
    if (a_ctl !== CTL_NONE) begin
      n_bad++; $display("FAIL load_use_unused: ctl %b expected %b", a_ctl, CTL_NONE);
    end
    tick();
    s.id_u1 = 1'b1; s.ex_dst = 5'd0; s.id_rs1 = 5'd0;
    apply(s);
    n_cmp++;
    if (a_ctl !== CTL_NONE) begin
      n_bad++; $display("FAIL load_use_x0: ctl %b expected %b", a_ctl, CTL_NONE);
    end
    tick();
    // A plain ALU producer only stalls when there is no forwarding path.
    s = idle_stim();
    s.ex_dst = 5'd6; s.ex_we = 1'b1; s.id_rs2 = 5'd6; s.id_u2 = 1'b1;
    apply(s);
    n_cmp++;
    if (a_ctl !== (FWD_ON ? CTL_NONE : CTL_STALL)) begin
      n_bad++; $display("FAIL alu_producer: ctl %b expected %b", a_ctl, FWD_ON ? CTL_NONE : CTL_STALL);
    end
    tick();
    apply(idle_stim());
    tick();
  endtask

  task automatic test_forward();
    stim_t s;
    logic [1:0] f_mem, f_wb;
    f_mem = FWD_ON ? 2'b01 : 2'b00;
    f_wb  = FWD_ON ? 2'b10 : 2'b00;
    s = idle_stim();
    s.mem_dst = 5'd7; s.mem_we = 1'b1; s.wb_dst = 5'd7; s.wb_we = 1'b1; s.ex_rs2 = 5'd7;
    apply(s);
    n_cmp++;
    if (o_ctr_Fwd2Sel !== f_mem || o_ctr_Fwd1Sel !== 2'b00) begin
      n_bad++; $display("FAIL fwd_mem_wins: fwd2 %b fwd1 %b expected %b 00", o_ctr_Fwd2Sel, o_ctr_Fwd1Sel, f_mem);
    end
    tick();
    s.mem_dst = 5'd0;
    apply(s);
    n_cmp++;
    if (o_ctr_Fwd2Sel !== f_wb) begin
      n_bad++; $display("FAIL fwd_mem_x0: fwd2 %b expected %b", o_ctr_Fwd2Sel, f_wb);
    end
    tick();
    s.mem_dst = 5'd7; s.mem_we = 1'b0;
    apply(s);
    n_cmp++;
    if (o_ctr_Fwd2Sel !== f_wb) begin
      n_bad++; $display("FAIL fwd_mem_noen: fwd2 %b expected %b", o_ctr_Fwd2Sel, f_wb);
    end
    tick();
    s = idle_stim();
    s.mem_dst = 5'd3; s.mem_we = 1'b1; s.wb_dst = 5'd4; s.wb_we = 1'b1;
    s.ex_rs1 = 5'd4; s.ex_rs2 = 5'd3;
    apply(s);
    n_cmp++;
    if (o_ctr_Fwd1Sel !== f_wb || o_ctr_Fwd2Sel !== f_mem) begin
      n_bad++; $display("FAIL fwd_split: fwd1 %b fwd2 %b expected %b %b",
                        o_ctr_Fwd1Sel, o_ctr_Fwd2Sel, f_wb, f_mem);
    end
    tick();
  endtask

  task automatic test_redirect();
    stim_t s;
    int fc;
    fc = m_flush_cnt;
    s = idle_stim();
    s.br = 1'b1; s.zero = 1'b1;
    s.ex_dst = 5'd3; s.ex_we = 1'b1; s.ex_ld = 1'b1; s.id_rs2 = 5'd3; s.id_u2 = 1'b1;
    apply(s);
    n_cmp++;
    if (a_ctl !== CTL_REDIR) begin
      n_bad++; $display("FAIL redirect_priority: ctl %b expected %b", a_ctl, CTL_REDIR);
    end
    tick();
    s.br = 1'b0;
    apply(s);
    n_cmp++;
    if (o_ctr_State !== 2'd2 || {16'd0, o_ctr_FlushCnt} !== fc + 1 || a_ctl !== CTL_NONE) begin
      n_bad++; $display("FAIL redirect_state: state %0d cnt %0d ctl %b expected 2 %0d %b",
                        o_ctr_State, o_ctr_FlushCnt, a_ctl, fc + 1, CTL_NONE);
    end
    tick();
    s = idle_stim();
    s.jmp = 1'b1;
    apply(s);
    n_cmp++;
    if (a_ctl !== CTL_REDIR) begin
      n_bad++; $display("FAIL redirect_jump: ctl %b expected %b", a_ctl, CTL_REDIR);
    end
    tick();
    s = idle_stim();
    s.br = 1'b1;
    apply(s);
    n_cmp++;
    if (a_ctl !== CTL_NONE) begin
      n_bad++; $display("FAIL branch_not_taken: ctl %b expected %b", a_ctl, CTL_NONE);
    end
    tick();
  endtask

  task automatic test_saturation();
    stim_t s;
    do_reset();
    s = idle_stim();
    s.ex_dst = 5'd9; s.ex_we = 1'b1; s.ex_ld = 1'b1; s.id_rs1 = 5'd9; s.id_u1 = 1'b1;
    drive(s);
    repeat (CNT_MAX - 1) @(posedge clk);
    #1;
    m_state = 1;
    m_stall_cnt = CNT_MAX - 1;
    apply(s);
    n_cmp++;
    if (o_ctr_StallCnt !== 16'hFFFE || a_ctl !== CTL_STALL) begin
      n_bad++; $display("FAIL sat_preload: cnt %h ctl %b expected fffe %b", o_ctr_StallCnt, a_ctl, CTL_STALL);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(s);
      n_cmp++;
      if (o_ctr_StallCnt !== 16'hFFFF || o_ctr_FlushCnt !== 16'd0) begin
        n_bad++; $display("FAIL sat_hold: stall %h flush %h expected ffff 0", o_ctr_StallCnt, o_ctr_FlushCnt);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    stim_t s;
    do_reset();
    s = idle_stim();
    s.ex_dst = 5'd9; s.ex_we = 1'b1; s.ex_ld = 1'b1; s.id_rs1 = 5'd9; s.id_u1 = 1'b1;
    s.mem_dst = 5'd6; s.mem_we = 1'b1; s.ex_rs1 = 5'd6;
    for (int i = 0; i < 9; i++) begin
      apply(s);
      tick();
    end
    #2;
    n_cmp++;
    if (o_ctr_StallCnt !== 16'd9 || o_ctr_State !== 2'd1) begin
      n_bad++; $display("FAIL pre_reset: cnt %0d state %0d expected 9 1", o_ctr_StallCnt, o_ctr_State);
    end
    assert_reset();
    #1;
    n_cmp++;
    if ({a_ctl, o_ctr_Fwd1Sel, o_ctr_Fwd2Sel} !== 10'd0 || o_ctr_StallCnt !== 16'd0 || o_ctr_State !== 2'd0) begin
      n_bad++; $display("FAIL reset_mid_stall: ctl %b fwd %b%b cnt %0d state %0d expected 0",
                        a_ctl, o_ctr_Fwd1Sel, o_ctr_Fwd2Sel, o_ctr_StallCnt, o_ctr_State);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply(s);
    n_cmp++;
    if (o_ctr_State !== 2'd0 || a_ctl !== CTL_STALL) begin
      n_bad++; $display("FAIL reset_release: state %0d ctl %b expected 0 %b", o_ctr_State, a_ctl, CTL_STALL);
    end
    tick();
    s = idle_stim();
    s.jmp = 1'b1;
    apply(s);
    tick();
    #2;
    assert_reset();
    #1;
    n_cmp++;
    if (o_ctr_State !== 2'd0 || o_ctr_FlushCnt !== 16'd0 || a_ctl !== CTL_NONE) begin
      n_bad++; $display("FAIL reset_mid_redirect: state %0d cnt %0d ctl %b expected 0 0 0",
                        o_ctr_State, o_ctr_FlushCnt, a_ctl);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply(idle_stim());
    n_cmp++;
    if (o_ctr_State !== 2'd0) begin
      n_bad++; $display("FAIL redirect_release: state %0d expected 0", o_ctr_State);
    end
    tick();
  endtask

  task automatic test_raw_no_fwd();
    stim_t s;
    logic [5:0] exp_ctl;
    exp_ctl = FWD_ON ? CTL_NONE : CTL_STALL;
    s = idle_stim();
    s.id_rs1 = 5'd4; s.id_u1 = 1'b1; s.wb_dst = 5'd4; s.wb_we = 1'b1; s.ex_rs1 = 5'd4;
    apply(s);
    n_cmp++;
    if (a_ctl !== exp_ctl || o_ctr_Fwd1Sel !== (FWD_ON ? 2'b10 : 2'b00)) begin
      n_bad++; $display("FAIL wb_raw: ctl %b fwd1 %b expected %b %b",
                        a_ctl, o_ctr_Fwd1Sel, exp_ctl, FWD_ON ? 2'b10 : 2'b00);
    end
    tick();
    apply(s);
    n_cmp++;
    if (a_ctl !== exp_ctl || o_ctr_State !== (FWD_ON ? 2'd0 : 2'd1)) begin
      n_bad++; $display("FAIL wb_raw_persist: ctl %b state %0d expected %b %0d",
                        a_ctl, o_ctr_State, exp_ctl, FWD_ON ? 0 : 1);
    end
    tick();
    apply(idle_stim());
    tick();
  endtask

  task automatic test_random();
    stim_t s;
    int prev_state;
    prev_state = m_state;
    for (int i = 0; i < 3000; i++) begin
      s = rand_stim();
`ifdef HAZARD_FORWARD_EN
      if (m_state == 1) begin
        s.ex_we = 1'b0; s.ex_ld = 1'b0;
      end
`endif
      apply(s);
      n_cmp++;
      if (a_ctl !== e_ctl || o_ctr_Fwd1Sel !== e_f1 || o_ctr_Fwd2Sel !== e_f2) begin
        n_bad++; $display("FAIL rand_ctl[%0d]: ctl %b fwd %b%b expected %b %b%b",
                          i, a_ctl, o_ctr_Fwd1Sel, o_ctr_Fwd2Sel, e_ctl, e_f1, e_f2);
      end
      n_cmp++;
      if ({30'd0, o_ctr_State} !== m_state || {16'd0, o_ctr_StallCnt} !== m_stall_cnt ||
          {16'd0, o_ctr_FlushCnt} !== m_flush_cnt) begin
        n_bad++; $display("FAIL rand_status[%0d]: state %0d stall %0d flush %0d expected %0d %0d %0d",
                          i, o_ctr_State, o_ctr_StallCnt, o_ctr_FlushCnt, m_state, m_stall_cnt, m_flush_cnt);
      end
`ifdef HAZARD_FORWARD_EN
      n_cmp++;
      if (prev_state == 1 && o_ctr_State === 2'd1) begin
        n_bad++; $display("FAIL double_ldstall[%0d]: state %0d twice, expected a single stall cycle",
                          i, o_ctr_State);
      end
`endif
      prev_state = m_state;
      tick();
    end
  endtask

  initial begin
    drive(idle_stim());
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_forward();
    test_redirect();
    test_raw_no_fwd();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
